// File: rtl/ws2812_pkg.sv
// Shared line codes, timing constants and sequencer state encoding for the
// WS2812B frame path.
package ws2812_pkg;

   localparam logic [1:0] QM_ZERO = 2'b00;
   localparam logic [1:0] QM_ONE  = 2'b01;
   localparam logic [1:0] QM_LOW  = 2'b10;
   localparam logic [1:0] QM_HIGH = 2'b11;

   localparam int BITS_PER_LED = 24;
   localparam int BIT_CYCLES   = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      DATA = 2'd2,
      TAIL = 2'd3
   } seq_state_t;

endpackage

// File: rtl/ws2812_frame_seq.sv
// Frame sequencer: walks the pixel store, serialises GRB words MSB-first as
// per-bit line codes paced by bdone, then holds the line low for the reset tail.
module ws2812_frame_seq
   import ws2812_pkg::*;
#(
   parameter int NUM_LEDS   = 8,
   parameter int RESET_BITS = 220,
   parameter int ADDR_W     = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [23:0]       pix_data,
   output logic [ADDR_W-1:0] pix_addr,
   input  logic              bdone,
   output logic [1:0]        qmode,
   output logic              startcoding,
   output logic              busy,
   output logic              frame_done
);

   localparam int TAIL_W = $clog2(RESET_BITS + 1);

   localparam logic [ADDR_W-1:0] LAST_LED  = ADDR_W'(NUM_LEDS - 1);
   localparam logic [TAIL_W-1:0] LAST_TAIL = TAIL_W'(RESET_BITS - 1);
   localparam logic [4:0]        LAST_BIT  = 5'(BITS_PER_LED - 1);

   seq_state_t        state;
   logic [23:0]       shreg;
   logic [4:0]        bitcnt;
   logic [ADDR_W-1:0] ledcnt;
   logic [TAIL_W-1:0] tailcnt;
   logic [ADDR_W-1:0] next_addr;

   // The address sticks at the last LED so the store is never read out of range.
   assign next_addr = (pix_addr == LAST_LED) ? pix_addr : pix_addr + ADDR_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         qmode       <= QM_LOW;
         startcoding <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         pix_addr    <= '0;
         shreg       <= '0;
         bitcnt      <= '0;
         ledcnt      <= '0;
         tailcnt     <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               qmode <= QM_LOW;
               busy  <= 1'b0;
               if (start) begin
                  shreg       <= pix_data;
                  pix_addr    <= next_addr;
                  startcoding <= 1'b1;
                  busy        <= 1'b1;
                  state       <= SYNC;
               end
            end

            // Line held low for the one cycle in which the bit generator
            // counter is being cleared; the first bit starts on the next edge.
            SYNC: begin
               startcoding <= 1'b0;
               qmode       <= {1'b0, shreg[23]};
               bitcnt      <= '0;
               ledcnt      <= '0;
               state       <= DATA;
            end

            DATA: begin
               if (bdone) begin
                  if (bitcnt != LAST_BIT) begin
                     shreg  <= {shreg[22:0], 1'b0};
                     bitcnt <= bitcnt + 5'd1;
                     qmode  <= {1'b0, shreg[22]};
                  end else if (ledcnt != LAST_LED) begin
                     shreg    <= pix_data;
                     ledcnt   <= ledcnt + ADDR_W'(1);
                     pix_addr <= next_addr;
                     bitcnt   <= '0;
                     qmode    <= {1'b0, pix_data[23]};
                  end else begin
                     qmode   <= QM_LOW;
                     tailcnt <= '0;
                     state   <= TAIL;
                  end
               end
            end

            TAIL: begin
               qmode <= QM_LOW;
               if (bdone) begin
                  if (tailcnt == LAST_TAIL) begin
                     frame_done <= 1'b1;
                     busy       <= 1'b0;
                     pix_addr   <= '0;
                     tailcnt    <= '0;
                     state      <= IDLE;
                  end else begin
                     tailcnt <= tailcnt + TAIL_W'(1);
                  end
               end
            end

            default: begin
               qmode <= QM_LOW;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ws2812_frame_seq.sv
// Self-checking bench for ws2812_frame_seq: a small 2-LED instance against a
// frame-level reference model, plus a default-parameter instance for tail timing.
module tb_ws2812_frame_seq;
   import ws2812_pkg::*;

   localparam int N         = 2;
   localparam int RB        = 4;
   localparam int AW        = 8;
   localparam int NB        = BITS_PER_LED * N + RB;
   localparam int FRAME_END = 2 + BIT_CYCLES * NB;
   localparam int D_N       = 8;
   localparam int D_RB      = 220;
   localparam int D_END     = 2 + BIT_CYCLES * (BITS_PER_LED * D_N + D_RB);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Line level produced by the bit generator for a code at a counter value.
   function automatic int line_level(input logic [1:0] q, input logic [6:0] b);
      case (q)
         2'b00:   return (b < 7'd36) ? 1 : 0;
         2'b01:   return (b < 7'd92) ? 1 : 0;
         2'b11:   return 1;
         default: return 0;
      endcase
   endfunction

   // ---------------- small instance ----------------
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [23:0]   pix_data;
   logic [AW-1:0] pix_addr;
   logic          bdone;
   logic [1:0]    qmode;
   logic          startcoding;
   logic          busy;
   logic          frame_done;
   logic [23:0]   pix [0:N-1];
   logic [6:0]    bcount = 7'd0;
   logic          force_bdone = 1'b0;

   assign pix_data = (int'(pix_addr) < N) ? pix[int'(pix_addr)] : 24'hDEAD00;
   assign bdone    = (bcount == 7'd127) || force_bdone;

   always @(posedge clk) bcount <= startcoding ? 7'd0 : bcount + 7'd1;

   ws2812_frame_seq #(.NUM_LEDS(N), .RESET_BITS(RB), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .pix_data(pix_data),
      .pix_addr(pix_addr), .bdone(bdone), .qmode(qmode),
      .startcoding(startcoding), .busy(busy), .frame_done(frame_done)
   );

   // Reference model: mc is the index of the current cycle within a frame,
   // cycle 0 being the one in which the accepted start was high.
   int          mc = -1;
   logic [23:0] snap [0:N-1];

   always @(posedge clk) begin
      if (reset) mc = -1;
      else if (mc >= 1 && mc < FRAME_END) mc++;
      else if (start) begin
         mc = 1;
         for (int i = 0; i < N; i++) snap[i] = pix[i];
      end else mc = -1;
   end

   int hi = 0;
   int cap [0:NB-1];
   int fd_cnt = 0;

   always @(negedge clk) begin
      int e_q, e_addr, e_busy, e_sc, e_fd, p, led, off, lvl, e_hi;
      e_q = 2; e_addr = 0; e_busy = 0; e_sc = 0; e_fd = 0; p = 0;
      if (frame_done) fd_cnt++;
      if (mc >= 1 && mc < FRAME_END) begin
         e_busy = 1;
         if (mc == 1) begin
            e_sc   = 1;
            e_addr = (N > 1) ? 1 : 0;
         end else begin
            p      = (mc - 2) / BIT_CYCLES;
            led    = (p / BITS_PER_LED < N - 1) ? p / BITS_PER_LED : N - 1;
            e_addr = (led + 1 < N - 1) ? led + 1 : N - 1;
            if (p < BITS_PER_LED * N)
               e_q = int'(snap[p / BITS_PER_LED][23 - p % BITS_PER_LED]);
         end
      end else if (mc == FRAME_END) e_fd = 1;
      chk("qmode", int'(qmode), e_q);
      chk("pix_addr", int'(pix_addr), e_addr);
      chk("busy", int'(busy), e_busy);
      chk("startcoding", int'(startcoding), e_sc);
      chk("frame_done", int'(frame_done), e_fd);
      lvl = line_level(qmode, bcount);
      if (mc == 1) chk("sync_line_low", lvl, 0);
      if (mc >= 2 && mc < FRAME_END) begin
         off = (mc - 2) % BIT_CYCLES;
         if (off == 0) hi = 0;
         hi += lvl;
         if (off == 64) cap[p] = int'(qmode);
         if (off == BIT_CYCLES - 1) begin
            e_hi = (e_q == 0) ? 36 : (e_q == 1) ? 92 : 0;
            chk("high_time", hi, e_hi);
         end
      end
   end

   task automatic run_frame(input int busy_at, input int reset_at,
                            input bit sync_force, output int len);
      int t;
      bit done;
      start = 1'b1;
      t = 0; done = 1'b0; len = -1;
      while (!done) begin
         @(negedge clk);
         t++;
         start       = (busy_at != 0 && t == busy_at);
         force_bdone = (sync_force && t == 1);
         if (reset_at != 0 && t == reset_at) begin
            #3 reset = 1'b1;
            #1;
            chk("rst_qmode", int'(qmode), 2);
            chk("rst_busy", int'(busy), 0);
            chk("rst_pix_addr", int'(pix_addr), 0);
            chk("rst_startcoding", int'(startcoding), 0);
            @(negedge clk);
            reset = 1'b0;
            done = 1'b1;
         end else if (frame_done) begin
            len = t;
            done = 1'b1;
         end else if (t > FRAME_END + 100) begin
            chk("frame_timeout", t, FRAME_END);
            done = 1'b1;
         end
      end
      start = 1'b0;
      force_bdone = 1'b0;
   endtask

   task automatic check_caps(input logic [23:0] l0, input logic [23:0] l1);
      for (int i = 0; i < BITS_PER_LED; i++) begin
         chk("lit_led0_bit", cap[i], int'(l0[23 - i]));
         chk("lit_led1_bit", cap[BITS_PER_LED + i], int'(l1[23 - i]));
      end
      for (int i = 0; i < RB; i++) chk("lit_tail_code", cap[2 * BITS_PER_LED + i], 2);
   endtask

   task automatic small_seq();
      int len;
      pix[0] = 24'hA50F01;
      pix[1] = 24'h00FF80;
      repeat (3) @(negedge clk);
      chk("reset_qmode", int'(qmode), 2);
      chk("reset_busy", int'(busy), 0);
      chk("reset_startcoding", int'(startcoding), 0);
      chk("reset_frame_done", int'(frame_done), 0);
      chk("reset_pix_addr", int'(pix_addr), 0);
      reset = 1'b0;
      @(negedge clk);

      run_frame(3000, 0, 1'b0, len);
      $display("frame 1: length %0d", len);
      chk("frame1_len", len, 6658);
      @(negedge clk);
      chk("frame1_done_count", fd_cnt, 1);
      check_caps(24'hA50F01, 24'h00FF80);

      repeat (5) begin
         force_bdone = 1'b1;
         @(negedge clk);
      end
      force_bdone = 1'b0;
      chk("idle_bdone_qmode", int'(qmode), 2);
      chk("idle_bdone_busy", int'(busy), 0);
      chk("idle_bdone_sc", int'(startcoding), 0);
      repeat (3) @(negedge clk);

      run_frame(0, 0, 1'b1, len);
      $display("frame 2: length %0d", len);
      chk("frame2_len", len, 6658);
      @(negedge clk);
      chk("frame2_done_count", fd_cnt, 2);
      check_caps(24'hA50F01, 24'h00FF80);

      for (int k = 0; k < 3; k++) begin
         pix[0] = 24'($urandom);
         pix[1] = 24'($urandom);
         repeat ($urandom_range(1, 40)) @(negedge clk);
         if (k == 1) begin
            run_frame(0, int'($urandom_range(1400, 1600)), 1'b0, len);
            $display("random frame %0d: reset mid-frame", k);
            run_frame(0, 0, 1'b0, len);
         end else begin
            run_frame(int'($urandom_range(100, 6500)), 0, 1'b0, len);
         end
         $display("random frame %0d: pix %h %h length %0d", k, pix[0], pix[1], len);
         chk("rand_frame_len", len, FRAME_END);
      end
      @(negedge clk);
      chk("total_done_count", fd_cnt, 5);
   endtask

   // ---------------- default-parameter instance ----------------
   logic        d_reset = 1'b1;
   logic        d_start = 1'b0;
   logic [23:0] d_pix_data;
   logic [7:0]  d_pix_addr;
   logic        d_bdone;
   logic [1:0]  d_qmode;
   logic        d_startcoding;
   logic        d_busy;
   logic        d_frame_done;
   logic [6:0]  d_bcount = 7'd0;

   assign d_pix_data = {d_pix_addr, d_pix_addr ^ 8'h5A, 8'hC3};
   assign d_bdone    = (d_bcount == 7'd127);

   always @(posedge clk) d_bcount <= d_startcoding ? 7'd0 : d_bcount + 7'd1;

   ws2812_frame_seq dut_default (
      .clk(clk), .reset(d_reset), .start(d_start), .pix_data(d_pix_data),
      .pix_addr(d_pix_addr), .bdone(d_bdone), .qmode(d_qmode),
      .startcoding(d_startcoding), .busy(d_busy), .frame_done(d_frame_done)
   );

   task automatic default_seq();
      int t, tail, q3;
      bit done;
      repeat (3) @(negedge clk);
      d_reset = 1'b0;
      @(negedge clk);
      d_start = 1'b1;
      t = 0; tail = 0; q3 = 0; done = 1'b0;
      while (!done) begin
         @(negedge clk);
         t++;
         d_start = 1'b0;
         if (d_busy && d_qmode == QM_LOW && t > 1) tail++;
         if (d_qmode == QM_HIGH) q3++;
         if (d_frame_done) done = 1'b1;
         else if (t > D_END + 1000) begin
            chk("default_timeout", t, D_END);
            done = 1'b1;
         end
      end
      $display("default frame: length %0d tail %0d", t, tail);
      chk("default_len", t, 52738);
      chk("default_tail", tail, 28160);
      chk("default_tail_280us", int'(tail >= 28000), 1);
      chk("default_no_qm_high", q3, 0);
   endtask

   initial begin
      fork
         small_seq();
         default_seq();
      join
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
